axi4_master_write_response: RTL and testbench
=============================================

Name: axi4_master_write_response

Overview:
- Master-side AXI4 write-response (B) channel receiver; the initiator-end counterpart of the slave write-response block.
- The AW/W issue logic records each completed write burst (ID) here.
- The block accepts B beats with bready, matches bid against per-ID outstanding counters, and hands each response to the master core over a valid/ready interface.
- Flags unexpected IDs and error responses, and bounds the total number of outstanding writes.

Parameters:
- ID_WIDTH, 4, width of AXI ID fields.
- MAX_OUTSTANDING, 8, maximum total writes awaiting a response (1..255).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- issue_valid  input  1  write burst fully issued (W last beat handshaken).
- issue_id  input  ID_WIDTH  ID of the issued burst.
- issue_ready  output  1  room for another outstanding write.
- bid  input  ID_WIDTH  response ID from slave.
- bresp  input  2  response code from slave.
- bvalid  input  1  slave response valid.
- bready  output  1  master ready for response.
- resp_valid  output  1  response available to core.
- resp_ready  input  1  core accepts response.
- resp_id  output  ID_WIDTH  captured bid.
- resp_code  output  2  captured bresp.
- resp_unexp  output  1  captured bid had no outstanding write.
- outstanding  output  8  total writes awaiting response.
- err_count  output  16  saturating count of SLVERR/DECERR responses.
- timeout_err  output  1  watchdog fired; tied 0 when feature absent.

Behaviour:
- Reset state: all outputs 0, state IDLE, all per-ID counters 0. issue_ready is 1 out of reset. Reset asserted mid-operation discards all pending state immediately.
- Per-ID counters: 2**ID_WIDTH counters, each 8 bits wide. outstanding is the registered total of all counters.
- issue_ready = (outstanding < MAX_OUTSTANDING), registered.
- Issue: issue_valid && issue_ready increments cnt[issue_id] and outstanding. An issue while issue_ready=0 is ignored.
- B handshake (bvalid && bready):
  - If cnt[bid] > 0: decrement cnt[bid] and outstanding; resp_unexp=0.
  - If cnt[bid] == 0: counters unchanged (no underflow); resp_unexp=1.
- Simultaneous issue and B handshake:
  - Same ID: net counter change 0.
  - Different IDs: each counter updated independently; outstanding unchanged.
- FSM states:
  - IDLE: bready=0. Go to ACTIVE when outstanding becomes nonzero.
  - ACTIVE: bready=1. On B handshake, load resp_id/resp_code/resp_unexp, set resp_valid the next cycle, and go to HOLD.
  - HOLD: bready=0 and resp_valid=1, held stable until resp_ready. On resp_valid && resp_ready, clear resp_valid and go to ACTIVE if outstanding>0, else IDLE.
  - Default: IDLE.
- Unsolicited response: a bvalid arriving in IDLE is not accepted (bready=0). The slave must wait for outstanding>0.
- Latency and throughput:
  - B handshake to resp_valid: 1 cycle.
  - Maximum throughput: one response per 2 cycles when resp_ready is held high.
- err_count increments when a captured bresp is 2'b10 or 2'b11, at the B handshake; it saturates at 16'hFFFF. OKAY (00) and EXOKAY (01) do not count.
- bresp/bid are sampled only on the handshake cycle; values on other cycles are ignored.

Optional Feature:
- Macro AXI_B_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles while outstanding>0 with no B handshake.
  - It clears on any B handshake or when outstanding==0.
  - On reaching TIMEOUT_CYCLES it sets timeout_err, which stays sticky until reset. Counting stops at the limit.
- When undefined: no watchdog logic; timeout_err tied to 0.

Test Plan:
- Reset then issue ID 3, then slave drives bid=3 bresp=00 -> bready=1 in ACTIVE; resp_valid one cycle after handshake with resp_id=3, resp_code=00, resp_unexp=0; outstanding 1->0; state returns to IDLE.
- Issue 8 writes (IDs 0..7) -> issue_ready drops to 0 after the 8th; a 9th issue_valid is ignored (outstanding stays 8); retiring one response restores issue_ready=1.
- Outstanding ID 2, slave returns bid=5 -> resp_unexp=1; cnt[5] stays 0; cnt[2] stays 1; outstanding stays 1.
- Hold resp_ready=0 for 5 cycles after capture -> bready=0 and resp_id/resp_code stable throughout; a second queued bvalid is not accepted until resp_ready=1.
- Responses bresp=10, then 11, then 01 -> err_count=2. Issue ID 4 in the same cycle as B handshake for bid=4 -> cnt[4] unchanged and outstanding unchanged.
- With AXI_B_TIMEOUT_EN and TIMEOUT_CYCLES=16: issue ID 1 and never drive bvalid -> timeout_err=1 after 16 cycles and stays 1. Without the macro -> timeout_err stays 0.

Source files
------------

// File: rtl/axi4_master_write_response.sv
// ============================================================================
// Module      : axi4_master_write_response
// Description : AXI4 master B-channel receiver with per-ID outstanding
//               tracking and a valid/ready handoff to the master core.
//               Optional watchdog enabled by defining AXI_B_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi4_master_write_response #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ID_WIDTH-1:0] issue_id,
  output logic                issue_ready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_WIDTH-1:0] resp_id,
  output logic [1:0]          resp_code,
  output logic                resp_unexp,
  output logic [7:0]          outstanding,
  output logic [15:0]         err_count,
  output logic                timeout_err
);

  localparam int         c_num_ids  = 2 ** ID_WIDTH;
  localparam logic [7:0] c_max_out  = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q [c_num_ids];
  logic [7:0]            cnt_d [c_num_ids];
  logic [7:0]            outstanding_q, outstanding_d;
  logic                  issue_ready_q, issue_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [1:0]            resp_code_q, resp_code_d;
  logic                  resp_unexp_q, resp_unexp_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  w_issue, w_b_hs, w_known, w_retire;

  always_comb begin
    w_issue  = issue_valid && issue_ready_q;
    w_b_hs   = bvalid && (state_q == ACTIVE);
    w_known  = (cnt_q[bid] != 8'd0);
    w_retire = w_b_hs && w_known;

    // Unknown IDs never decrement, so counters cannot underflow.
    for (int i = 0; i < c_num_ids; i++) begin
      cnt_d[i] = cnt_q[i]
               + {7'd0, w_issue  && (issue_id == ID_WIDTH'(i))}
               - {7'd0, w_retire && (bid      == ID_WIDTH'(i))};
    end

    outstanding_d = outstanding_q + {7'd0, w_issue} - {7'd0, w_retire};
    issue_ready_d = (outstanding_d < c_max_out);

    err_count_d = err_count_q;
    if (w_b_hs && bresp[1] && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_code_d  = resp_code_q;
    resp_unexp_d = resp_unexp_q;
    case (state_q)
      IDLE: begin
        if (outstanding_d != 8'd0) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (w_b_hs) begin
          resp_id_d    = bid;
          resp_code_d  = bresp;
          resp_unexp_d = !w_known;
          resp_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = (outstanding_d != 8'd0) ? ACTIVE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      outstanding_q <= 8'd0;
      issue_ready_q <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_code_q   <= 2'b00;
      resp_unexp_q  <= 1'b0;
      err_count_q   <= 16'd0;
      for (int i = 0; i < c_num_ids; i++) cnt_q[i] <= 8'd0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      issue_ready_q <= issue_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_code_q   <= resp_code_d;
      resp_unexp_q  <= resp_unexp_d;
      err_count_q   <= err_count_d;
      for (int i = 0; i < c_num_ids; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef AXI_B_TIMEOUT_EN
  localparam logic [15:0] c_timeout_lim = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd_q, wd_d;
  logic        timeout_err_q, timeout_err_d;

  // Counter parks at the limit; the flag is sticky until reset.
  always_comb begin
    if (w_b_hs || (outstanding_q == 8'd0)) begin
      wd_d = 16'd0;
    end else if (wd_q < c_timeout_lim) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = wd_q;
    end
    timeout_err_d = timeout_err_q || (wd_d == c_timeout_lim);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q          <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign issue_ready = issue_ready_q;
  assign bready      = (state_q == ACTIVE);
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_code   = resp_code_q;
  assign resp_unexp  = resp_unexp_q;
  assign outstanding = outstanding_q;
  assign err_count   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_master_write_response.sv
// ============================================================================
// Module      : tb_axi4_master_write_response
// Description : Directed self-checking bench for axi4_master_write_response.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_axi4_master_write_response;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_id = 4'd0;
  logic        issue_ready;
  logic [3:0]  bid = 4'd0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_id;
  logic [1:0]  resp_code;
  logic        resp_unexp;
  logic [7:0]  outstanding;
  logic [15:0] err_count;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  axi4_master_write_response #(
    .ID_WIDTH       (4),
    .MAX_OUTSTANDING(8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_id   (issue_id),
    .issue_ready(issue_ready),
    .bid        (bid),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_code  (resp_code),
    .resp_unexp (resp_unexp),
    .outstanding(outstanding),
    .err_count  (err_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id);
    issue_valid = 1'b1;
    issue_id    = id;
    tick();
    issue_valid = 1'b0;
  endtask

  // Present one B beat and wait (bounded) for it to be taken.
  task automatic b_beat(input logic [3:0] id, input logic [1:0] code);
    bit done = 0;
    bvalid = 1'b1;
    bid    = id;
    bresp  = code;
    for (int c = 0; c < 50 && !done; c++) begin
      if (bready) done = 1;
      tick();
    end
    bvalid = 1'b0;
    if (!done) check("b_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_valid_cleared", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_resp_valid",  32'(resp_valid),  32'd0);
    check("rst_bready",      32'(bready),      32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err_count",   32'(err_count),   32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_timeout",     32'(timeout_err), 32'd0);
    rst = 1'b1;
    tick();

    // Single transaction round trip
    issue(4'd3);
    check("t1_outstanding", 32'(outstanding), 32'd1);
    check("t1_bready",      32'(bready),      32'd1);
    b_beat(4'd3, 2'b00);
    check("t1_resp_valid",  32'(resp_valid),  32'd1);
    check("t1_resp_id",     32'(resp_id),     32'd3);
    check("t1_resp_code",   32'(resp_code),   32'd0);
    check("t1_resp_unexp",  32'(resp_unexp),  32'd0);
    check("t1_outst_zero",  32'(outstanding), 32'd0);
    check("t1_bready_hold", 32'(bready),      32'd0);
    accept();
    check("t1_idle_bready", 32'(bready),      32'd0);

    // Fill to the outstanding limit
    for (int i = 0; i < 8; i++) issue(4'(i));
    check("t2_outstanding_full", 32'(outstanding), 32'd8);
    check("t2_issue_ready_low",  32'(issue_ready), 32'd0);
    issue(4'd8);
    check("t2_ignored_issue",    32'(outstanding), 32'd8);
    b_beat(4'd0, 2'b00);
    check("t2_outstanding_7",    32'(outstanding), 32'd7);
    check("t2_issue_ready_back", 32'(issue_ready), 32'd1);
    accept();
    for (int i = 1; i < 8; i++) begin
      b_beat(4'(i), 2'b00);
      check("t2_drain_id",    32'(resp_id),    32'(i));
      check("t2_drain_unexp", 32'(resp_unexp), 32'd0);
      accept();
    end
    check("t2_drained", 32'(outstanding), 32'd0);
    check("t2_idle",    32'(bready),      32'd0);

    // Unexpected ID
    issue(4'd2);
    b_beat(4'd5, 2'b00);
    check("t3_unexp",       32'(resp_unexp),  32'd1);
    check("t3_outstanding", 32'(outstanding), 32'd1);
    accept();
    b_beat(4'd5, 2'b00);
    check("t3_unexp_again", 32'(resp_unexp),  32'd1);
    accept();
    b_beat(4'd2, 2'b00);
    check("t3_id2_known",   32'(resp_unexp),  32'd0);
    check("t3_outst_zero",  32'(outstanding), 32'd0);
    accept();

    // Backpressure from the core
    issue(4'd6);
    issue(4'd7);
    b_beat(4'd6, 2'b01);
    bvalid = 1'b1; bid = 4'd7; bresp = 2'b00;
    for (int c = 0; c < 5; c++) begin
      check("t4_bready_low",  32'(bready),      32'd0);
      check("t4_resp_valid",  32'(resp_valid),  32'd1);
      check("t4_resp_id",     32'(resp_id),     32'd6);
      check("t4_resp_code",   32'(resp_code),   32'd1);
      check("t4_outstanding", 32'(outstanding), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t4_released",    32'(resp_valid),  32'd0);
    check("t4_bready_back", 32'(bready),      32'd1);
    tick();
    bvalid = 1'b0;
    check("t4_second_id",   32'(resp_id),     32'd7);
    check("t4_second_code", 32'(resp_code),   32'd0);
    check("t4_outst_zero",  32'(outstanding), 32'd0);
    accept();
    check("t4_err_okay",    32'(err_count),   32'd0);

    // Error counting
    issue(4'd1); issue(4'd1); issue(4'd1);
    b_beat(4'd1, 2'b10); accept();
    check("t5_err_1", 32'(err_count), 32'd1);
    b_beat(4'd1, 2'b11); accept();
    b_beat(4'd1, 2'b01); accept();
    check("t5_err_2", 32'(err_count), 32'd2);

    // Simultaneous issue and retire, same ID
    issue(4'd4); issue(4'd4);
    issue_valid = 1'b1; issue_id = 4'd4;
    bvalid = 1'b1; bid = 4'd4; bresp = 2'b00;
    check("t6_bready_pre", 32'(bready), 32'd1);
    tick();
    issue_valid = 1'b0; bvalid = 1'b0;
    check("t6_same_outst", 32'(outstanding), 32'd2);
    check("t6_same_unexp", 32'(resp_unexp),  32'd0);
    accept();
    b_beat(4'd4, 2'b00);
    check("t6_drain1", 32'(outstanding), 32'd1);
    accept();
    b_beat(4'd4, 2'b00);
    check("t6_drain2_unexp", 32'(resp_unexp),  32'd0);
    check("t6_drain2",       32'(outstanding), 32'd0);
    accept();

    // Simultaneous issue and retire, different IDs
    issue(4'd9);
    issue_valid = 1'b1; issue_id = 4'd10;
    bvalid = 1'b1; bid = 4'd9; bresp = 2'b00;
    tick();
    issue_valid = 1'b0; bvalid = 1'b0;
    check("t7_diff_outst", 32'(outstanding), 32'd1);
    check("t7_diff_unexp", 32'(resp_unexp),  32'd0);
    accept();
    b_beat(4'd10, 2'b00);
    check("t7_id10_known", 32'(resp_unexp),  32'd0);
    check("t7_outst_zero", 32'(outstanding), 32'd0);
    accept();

    // Watchdog
    issue(4'd1);
    for (int c = 0; c < 20; c++) tick();
`ifdef AXI_B_TIMEOUT_EN
    check("t8_timeout_set", 32'(timeout_err), 32'd1);
`else
    check("t8_timeout_off", 32'(timeout_err), 32'd0);
`endif
    b_beat(4'd1, 2'b00);
    accept();
    for (int c = 0; c < 5; c++) tick();
`ifdef AXI_B_TIMEOUT_EN
    check("t8_timeout_sticky", 32'(timeout_err), 32'd1);
`else
    check("t8_timeout_still0", 32'(timeout_err), 32'd0);
`endif

    // Reset mid-operation
    issue(4'd5);
    check("t9_pre_reset", 32'(outstanding), 32'd1);
    rst = 1'b0;
    tick();
    check("t9_outstanding", 32'(outstanding), 32'd0);
    check("t9_issue_ready", 32'(issue_ready), 32'd1);
    check("t9_bready",      32'(bready),      32'd0);
    check("t9_err_count",   32'(err_count),   32'd0);
    check("t9_timeout",     32'(timeout_err), 32'd0);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
